// File: rtl/capture_scheduler.sv
// Capture scheduler: arbitrates shutter-button and interval auto-capture requests,
// sequences one frame through RE_control and guards each wait phase with a watchdog.
module capture_scheduler #(
  parameter int INT_W  = 8,
  parameter int TO_CYC = 64,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn,
  input  logic             auto_en,
  input  logic [INT_W-1:0] interval,
  input  logic             exp_inc_in,
  input  logic             exp_dec_in,
  input  logic             expose,
  input  logic             adc,
  output logic             init,
  output logic             exp_inc,
  output logic             exp_dec,
  output logic             busy,
  output logic             frame_done,
  output logic             req_drop,
  output logic             timeout_err,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int WD_W = $clog2(TO_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TO_CYC - 1);

  typedef enum logic [2:0] {IDLE, START, W_EXP, W_ADC, W_END, DONE} state_t;

  state_t            state, state_nxt;
  logic              btn_prev, btn_pend, auto_pend;
  logic [INT_W-1:0]  tcnt;
  logic [WD_W-1:0]   wdog, wdog_nxt;
  logic              btn_edge, take_btn, take_any, wd_trip;

  assign btn_edge = btn & ~btn_prev;

  // Next-state logic; wdog is zeroed on every entry into a wait state.
  always_comb begin
    state_nxt = state;
    wdog_nxt  = wdog;
    take_btn  = 1'b0;
    take_any  = 1'b0;
    wd_trip   = 1'b0;
    case (state)
      IDLE: begin
        if (btn_pend) begin
          take_btn  = 1'b1;
          take_any  = 1'b1;
          state_nxt = START;
        end else if (auto_pend) begin
          take_any  = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        state_nxt = W_EXP;
        wdog_nxt  = '0;
      end
      W_EXP: begin
        if (expose) begin
          state_nxt = W_ADC;
          wdog_nxt  = '0;
        end else if (wdog == WD_LAST) begin
          wd_trip   = 1'b1;
          state_nxt = IDLE;
        end else begin
          wdog_nxt = wdog + 1'b1;
        end
      end
      W_ADC: begin
        if (adc) begin
          state_nxt = W_END;
          wdog_nxt  = '0;
        end else if (wdog == WD_LAST) begin
          wd_trip   = 1'b1;
          state_nxt = IDLE;
        end else begin
          wdog_nxt = wdog + 1'b1;
        end
      end
      W_END: begin
        if (!adc) begin
          state_nxt = DONE;
        end else if (wdog == WD_LAST) begin
          wd_trip   = 1'b1;
          state_nxt = IDLE;
        end else begin
          wdog_nxt = wdog + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wdog  <= '0;
    end else begin
      state <= state_nxt;
      wdog  <= wdog_nxt;
    end
  end

  // Request capture: a new edge wins over consumption in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_prev  <= 1'b0;
      btn_pend  <= 1'b0;
      req_drop  <= 1'b0;
      auto_pend <= 1'b0;
      tcnt      <= '0;
    end else begin
      btn_prev <= btn;
      btn_pend <= btn_edge | (btn_pend & ~take_btn);
      req_drop <= btn_edge & btn_pend & ~take_btn;
      if (!auto_en || interval == '0) begin
        tcnt      <= interval;
        auto_pend <= 1'b0;
      end else if (tcnt <= INT_W'(1)) begin
        tcnt      <= interval;
        auto_pend <= 1'b1;
      end else begin
        tcnt      <= tcnt - 1'b1;
        auto_pend <= auto_pend & ~take_any;
      end
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init        <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      exp_inc     <= 1'b0;
      exp_dec     <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      init       <= (state_nxt == START);
      busy       <= (state_nxt != IDLE);
      frame_done <= (state_nxt == DONE);
      exp_inc    <= exp_inc_in & ~exp_dec_in & (state == IDLE);
      exp_dec    <= exp_dec_in & ~exp_inc_in & (state == IDLE);
      if (state == DONE) begin
        frame_cnt   <= frame_cnt + 1'b1;
        timeout_err <= 1'b0;
      end else if (wd_trip) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_capture_scheduler.sv
// Directed bench for capture_scheduler; cycle numbers in comments count rising edges
// after reset release, each check taken 1 time unit after that edge.
module tb_capture_scheduler;

  logic       clk = 1'b0;
  logic       reset, btn, auto_en, exp_inc_in, exp_dec_in, expose, adc;
  logic [7:0] interval;
  logic       init, exp_inc, exp_dec, busy, frame_done, req_drop, timeout_err;
  logic [7:0] frame_cnt;

  int vecs = 0;
  int errs = 0;

  capture_scheduler #(.INT_W(8), .TO_CYC(64), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .btn(btn), .auto_en(auto_en), .interval(interval),
    .exp_inc_in(exp_inc_in), .exp_dec_in(exp_dec_in), .expose(expose), .adc(adc),
    .init(init), .exp_inc(exp_inc), .exp_dec(exp_dec), .busy(busy),
    .frame_done(frame_done), .req_drop(req_drop), .timeout_err(timeout_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Called in the first W_EXP cycle; returns in the IDLE cycle after DONE.
  task automatic do_frame(input logic [7:0] cnt_after);
    expose = 1'b1;
    tick(1);
    expose = 1'b0;
    adc    = 1'b1;
    tick(1);
    adc = 1'b0;
    tick(1);
    check("frame_done_pulse", frame_done, 1);
    tick(1);
    check("frame_done_end", frame_done, 0);
    check("busy_after_frame", busy, 0);
    check("frame_cnt", frame_cnt, cnt_after);
  endtask

  initial begin
    reset = 1'b1; btn = 1'b0; auto_en = 1'b0; interval = 8'd0;
    exp_inc_in = 1'b0; exp_dec_in = 1'b0; expose = 1'b0; adc = 1'b0;
    tick(2);
    check("rst_init", init, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_req_drop", req_drop, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_exp", {exp_inc, exp_dec}, 0);
    reset = 1'b0;                       // cycle 0

    // Button frame: edge sampled at cycle 5, init at 6, frame_done at 16
    tick(4);
    btn = 1'b1;
    tick(1);                            // 5
    check("t1_init_c5", init, 0);
    check("t1_busy_c5", busy, 0);
    tick(1);                            // 6
    check("t1_init_c6", init, 1);
    check("t1_busy_c6", busy, 1);
    btn = 1'b0;
    tick(1);                            // 7: W_EXP
    check("t1_init_c7", init, 0);
    tick(1);                            // 8
    expose = 1'b1;
    tick(1);                            // 9: W_ADC
    expose = 1'b0;
    tick(3);                            // 12
    adc = 1'b1;
    tick(1);                            // 13: W_END
    tick(2);                            // 15
    adc = 1'b0;
    check("t1_done_c15", frame_done, 0);
    tick(1);                            // 16: DONE
    check("t1_done_c16", frame_done, 1);
    check("t1_busy_c16", busy, 1);
    check("t1_cnt_c16", frame_cnt, 0);
    tick(1);                            // 17
    check("t1_busy_c17", busy, 0);
    check("t1_cnt_c17", frame_cnt, 1);

    // Exposure gating
    exp_inc_in = 1'b1;
    tick(1);                            // 18
    check("t5_inc_only", {exp_inc, exp_dec}, 2'b10);
    exp_dec_in = 1'b1;
    tick(1);                            // 19
    check("t5_both_in", {exp_inc, exp_dec}, 2'b00);
    exp_inc_in = 1'b0;
    tick(1);                            // 20
    check("t5_dec_only", {exp_inc, exp_dec}, 2'b01);
    exp_dec_in = 1'b0; exp_inc_in = 1'b1; btn = 1'b1;
    tick(1);                            // 21
    check("t5_inc_c21", exp_inc, 1);
    btn = 1'b0;
    tick(1);                            // 22: START
    check("t5_init_c22", init, 1);
    check("t5_inc_at_init", exp_inc, 1);
    tick(1);                            // 23: W_EXP
    check("t5_inc_after_init", exp_inc, 0);
    check("t5_init_single", init, 0);
    exp_inc_in = 1'b0;
    do_frame(8'd2);                     // 27

    // Button edge and auto expiry in the same cycle (interval 8)
    interval = 8'd8;
    tick(1);                            // 28: tcnt loaded
    auto_en = 1'b1;
    tick(7);                            // 35
    btn = 1'b1;
    tick(1);                            // 36: both pending
    btn = 1'b0;
    check("t3_idle_c36", busy, 0);
    tick(1);                            // 37
    check("t3_init_c37", init, 1);
    tick(1);                            // 38
    check("t3_init_once", init, 0);
    do_frame(8'd3);                     // 42
    tick(1);                            // 43
    check("t3_no_reissue_c43", busy, 0);
    tick(1);                            // 44
    check("t3_no_init_c44", init, 0);
    tick(1);                            // 45: next auto expiry served
    check("t2_auto_init_c45", init, 1);
    tick(1);                            // 46
    do_frame(8'd4);                     // 50
    tick(2);                            // 52
    check("t2_auto_idle_c52", init, 0);
    tick(1);                            // 53
    check("t2_auto_init_c53", init, 1);
    auto_en = 1'b0;

    // Two button edges while busy: the second is dropped
    tick(1);                            // 54: W_EXP
    btn = 1'b1;
    tick(1);                            // 55
    check("t3_drop_first", req_drop, 0);
    btn = 1'b0;
    tick(1);                            // 56
    btn = 1'b1;
    tick(1);                            // 57
    check("t3_drop_second", req_drop, 1);
    btn = 1'b0;
    tick(1);                            // 58
    check("t3_drop_pulse_end", req_drop, 0);
    do_frame(8'd5);                     // 62
    tick(1);                            // 63: pending button served
    check("t3_pend_served", init, 1);

    // Watchdog: W_EXP entered at 64, expose never rises
    tick(64);                           // 127
    check("t4_busy_c127", busy, 1);
    check("t4_to_c127", timeout_err, 0);
    tick(1);                            // 128
    check("t4_to_c128", timeout_err, 1);
    check("t4_idle_c128", busy, 0);
    check("t4_no_done", frame_done, 0);
    check("t4_cnt_kept", frame_cnt, 5);
    btn = 1'b1;
    tick(1);                            // 129
    btn = 1'b0;
    tick(2);                            // 131: W_EXP
    check("t4_to_sticky", timeout_err, 1);
    do_frame(8'd6);                     // 135
    check("t4_to_cleared", timeout_err, 0);

    // Reset during W_ADC with a button pending
    btn = 1'b1;
    tick(1);                            // 136
    btn = 1'b0;
    tick(1);                            // 137: START
    btn = 1'b1;
    tick(1);                            // 138: W_EXP, btn pending
    expose = 1'b1;
    tick(1);                            // 139: W_ADC
    reset = 1'b1; btn = 1'b0; expose = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_init", init, 0);
    check("t6_cnt", frame_cnt, 0);
    tick(1);
    reset = 1'b0;
    tick(3);
    check("t6_pend_cleared_busy", busy, 0);
    check("t6_pend_cleared_init", init, 0);

    // 256 frames: counter wraps back to 0
    for (int i = 0; i < 256; i++) begin
      btn = 1'b1;
      tick(1);
      btn = 1'b0;
      tick(2);
      do_frame(8'((i + 1) % 256));
    end
    check("t6_wrap_zero", frame_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
